// File: rtl/fifo_memory_pkg.sv
// Shared widths for the line-buffer FIFO storage; fifo_memory and its parent
// line buffer both take their defaults from here.
package fifo_memory_pkg;

    localparam int WID_FIFO  = 16;
    localparam int ADDR_FIFO = 10;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : fifo_memory_pkg

// File: rtl/fifo_memory.sv
// Simple dual-port RAM: one synchronous write port and one registered,
// read-first read port. It is used as a delay line by the parent line buffer.
module fifo_memory
    import fifo_memory_pkg::*;
#(
    parameter int DATA_W = WID_FIFO,
    parameter int ADDR_W = ADDR_FIFO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    // The zero initialiser only affects simulation; synthesis may ignore it.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;

    // The old word is sampled before the same edge writes, which gives
    // read-first collisions. The parent's delay-line behaviour depends on this.
    always_comb begin
        dout_d = dout_q;
        if (re) begin
            dout_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    // Reset does not clear the array; it only blocks writes.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= din;
        end
    end

    assign dout = dout_q;

endmodule : fifo_memory

// File: tb/tb_fifo_memory.sv
// Randomised and directed checks of fifo_memory against an array-based model
// of the RAM's read-first, registered-read behaviour.
module tb_fifo_memory;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;
    logic          re;
    logic [AW-1:0] raddr;
    logic [DW-1:0] dout;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] exp_dout;

    fifo_memory #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .din   (din),
        .re    (re),
        .raddr (raddr),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Update the model from the current inputs, take one edge, then check.
    task automatic cycle(input string tag);
        if (rst) begin
            exp_dout = '0;
        end else begin
            if (re) exp_dout = exp_mem[raddr];
            if (we) exp_mem[waddr] = din;
        end
        @(posedge clk);
        #1;
        chk(tag, dout, exp_dout);
    endtask

    task automatic drive(input logic w, input int wa, input int d, input logic r, input int ra);
        we    = w;
        waddr = AW'(wa);
        din   = DW'(d);
        re    = r;
        raddr = AW'(ra);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        exp_dout = '0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        chk("reset_dout", dout, 16'h0000);
        cycle("reset_hold");
        rst = 1'b0;

        // A location that was never written reads back as zero.
        drive(0, 0, 0, 1, 100);
        cycle("unwritten");
        chk("unwritten_zero", dout, 16'h0000);

        // Basic write, read, then hold.
        drive(1, 5, 16'hA5A5, 0, 0);
        cycle("wr5");
        drive(0, 0, 0, 1, 5);
        cycle("rd5");
        chk("rd5_val", dout, 16'hA5A5);
        drive(0, 0, 0, 0, 9);
        cycle("hold1");
        cycle("hold2");
        chk("hold_val", dout, 16'hA5A5);

        // Same-address read during write returns the old word.
        drive(1, 3, 16'h1111, 0, 0);
        cycle("wr3");
        drive(1, 3, 16'h2222, 1, 3);
        cycle("collide");
        chk("collide_old", dout, 16'h1111);
        drive(0, 0, 0, 1, 3);
        cycle("rd3_new");
        chk("rd3_new_val", dout, 16'h2222);

        // Address range boundaries.
        drive(1, 0, 16'h0F0F, 0, 0);
        cycle("wr0");
        drive(1, DEPTH - 1, 16'hF0F0, 0, 0);
        cycle("wr_top");
        drive(0, 0, 0, 1, 0);
        cycle("rd0");
        chk("rd0_val", dout, 16'h0F0F);
        drive(0, 0, 0, 1, DEPTH - 1);
        cycle("rd_top");
        chk("rd_top_val", dout, 16'hF0F0);

        // Write and read different addresses on the same edge.
        drive(1, 8, 16'hBEEF, 0, 0);
        cycle("wr8");
        drive(1, 7, 16'h00FF, 1, 8);
        cycle("indep");
        chk("indep_rd8", dout, 16'hBEEF);
        drive(0, 0, 0, 1, 7);
        cycle("rd7");
        chk("rd7_val", dout, 16'h00FF);

        // A four-entry delay line made with raddr == waddr.
        for (int i = 0; i < 12; i++) begin
            drive(1, i % 4, i + 1, 1, i % 4);
            cycle("delay_model");
            if (i >= 4) chk("delay_len4", dout, DW'(i + 1 - 4));
        end

        // An asynchronous reset in mid-cycle clears dout. Memory survives it,
        // and a write attempted during reset is ignored.
        drive(1, 20, 16'h1234, 0, 0);
        cycle("wr20");
        drive(0, 0, 0, 1, 20);
        cycle("rd20");
        chk("rd20_val", dout, 16'h1234);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", dout, 16'h0000);
        drive(1, 5, 16'hDEAD, 1, 5);
        cycle("rst_blocked");
        cycle("rst_blocked2");
        rst = 1'b0;
        drive(0, 0, 0, 1, 20);
        cycle("post_rst20");
        chk("post_rst20_val", dout, 16'h1234);
        drive(0, 0, 0, 1, 5);
        cycle("post_rst5");
        chk("post_rst5_val", dout, 16'hA5A5);

        // Random traffic on a small window so that collisions are frequent.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) waddr = AW'($urandom);
            if ($urandom_range(0, 9) == 0) raddr = AW'($urandom);
            cycle("random");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_memory
